// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU function codes, R-type opcodes, aluop
// encodings, the zero register index and the forwarding select helper.
package cpu_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [4:0] XZR = 5'd31;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_PASSB = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    // One held instruction slot of the ID/EX register.
    typedef struct packed {
        logic [4:0]      rn;
        logic [4:0]      rm;
        logic [4:0]      rd;
        logic [XLEN-1:0] rn_data;
        logic [XLEN-1:0] rm_data;
        logic [XLEN-1:0] imm;
        logic            alusrc;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic [3:0]      aluctrl;
    } idex_slot_t;

    // EX/MEM has the youngest result, so it wins over MEM/WB; XZR never forwards.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      src,
        input logic [XLEN-1:0] held,
        input logic            ex_we,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_res,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_res
    );
        logic [XLEN-1:0] val;
        val = held;
        if (src != XZR) begin
            if (ex_we && (ex_rd == src)) begin
                val = ex_res;
            end else if (wb_we && (wb_rd == src)) begin
                val = wb_res;
            end
        end
        return val;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop + opcode -> 4-bit ALU function code.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [1:0]  aluop_i,
    input  logic [10:0] opcode_i,
    output logic [3:0]  alu_ctrl_o
);

    // Unknown R-type opcodes and the reserved aluop fall back to ADD.
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (aluop_e'(aluop_i))
            ALUOP_ADD:   alu_ctrl_o = ALU_ADD;
            ALUOP_PASSB: alu_ctrl_o = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (opcode_i)
                    OPC_ADD: alu_ctrl_o = ALU_ADD;
                    OPC_SUB: alu_ctrl_o = ALU_SUB;
                    OPC_AND: alu_ctrl_o = ALU_AND;
                    OPC_ORR: alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default:     alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with operand select, load-use hazard detection
// and valid/ready handshake on both sides.
// Build option: FORWARDING_EN enables EX/MEM and MEM/WB operand forwarding;
// without it the held register-file values drive the ALU operands directly.
module idex_operand_stage
    import cpu_pkg::*;
(
    input  logic            CLK,
    input  logic            resetl,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [63:0]     in_rn_data,
    input  logic [63:0]     in_rm_data,
    input  logic [63:0]     in_imm,
    input  logic [4:0]      in_rn,
    input  logic [4:0]      in_rm,
    input  logic [4:0]      in_rd,
    input  logic [10:0]     in_opcode,
    input  logic [1:0]      in_aluop,
    input  logic            in_alusrc,
    input  logic            in_regwrite,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic            in_memtoreg,
    input  logic            flush,
    input  logic            exmem_regwrite,
    input  logic [4:0]      exmem_rd,
    input  logic [63:0]     exmem_result,
    input  logic            memwb_regwrite,
    input  logic [4:0]      memwb_rd,
    input  logic [63:0]     memwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     BusA,
    output logic [63:0]     BusB,
    output logic [3:0]      ALUCtrl,
    output logic [63:0]     out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic            out_memtoreg,
    output logic            hazard
);

    idex_slot_t slot_q, slot_d;
    logic       valid_q, valid_d;
    logic [3:0] alu_ctrl_dec;
    logic       uses_rm;
    logic       load_pending;
    logic       capture;
    logic [63:0] fwd_rn, fwd_rm;

    alu_ctrl_decode u_alu_ctrl_decode (
        .aluop_i    (in_aluop),
        .opcode_i   (in_opcode),
        .alu_ctrl_o (alu_ctrl_dec)
    );

    // Load-use detection against the incoming instruction's sources.
    always_comb begin
        uses_rm      = !in_alusrc || in_memwrite;
        load_pending = valid_q && slot_q.memread && (slot_q.rd != XZR);
        hazard       = load_pending &&
                       ((in_rn == slot_q.rd) || (uses_rm && (in_rm == slot_q.rd)));
        in_ready     = (!valid_q || out_ready) && !hazard && !flush;
        capture      = in_valid && in_ready;
    end

    // Next slot: flush beats capture, capture beats drain, otherwise hold.
    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d          = 1'b1;
            slot_d.rn        = in_rn;
            slot_d.rm        = in_rm;
            slot_d.rd        = in_rd;
            slot_d.rn_data   = in_rn_data;
            slot_d.rm_data   = in_rm_data;
            slot_d.imm       = in_imm;
            slot_d.alusrc    = in_alusrc;
            slot_d.regwrite  = in_regwrite;
            slot_d.memread   = in_memread;
            slot_d.memwrite  = in_memwrite;
            slot_d.memtoreg  = in_memtoreg;
            slot_d.aluctrl   = alu_ctrl_dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register; reset discards any held instruction.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            slot_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= valid_d;
        end
    end

`ifdef FORWARDING_EN
    // Operand forwarding from the later pipeline stages.
    always_comb begin
        fwd_rn = fwd_sel(slot_q.rn, slot_q.rn_data, exmem_regwrite, exmem_rd,
                         exmem_result, memwb_regwrite, memwb_rd, memwb_result);
        fwd_rm = fwd_sel(slot_q.rm, slot_q.rm_data, exmem_regwrite, exmem_rd,
                         exmem_result, memwb_regwrite, memwb_rd, memwb_result);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result,
                          slot_q.rn, slot_q.rm};

    // Forwarding disabled: operands come straight from the held register reads.
    always_comb begin
        fwd_rn = slot_q.rn_data;
        fwd_rm = slot_q.rm_data;
    end
`endif

    // Output drive; control bits are suppressed for an empty slot.
    always_comb begin
        out_valid      = valid_q;
        BusA           = fwd_rn;
        BusB           = slot_q.alusrc ? slot_q.imm : fwd_rm;
        out_store_data = fwd_rm;
        ALUCtrl        = slot_q.aluctrl;
        out_rd         = slot_q.rd;
        out_regwrite   = valid_q && slot_q.regwrite;
        out_memread    = valid_q && slot_q.memread;
        out_memwrite   = valid_q && slot_q.memwrite;
        out_memtoreg   = valid_q && slot_q.memtoreg;
    end

endmodule

// File: tb/tb_idex_operand_stage.sv
// Self-checking bench for idex_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural slot model.
module tb_idex_operand_stage;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        in_valid, in_ready;
    logic [63:0] in_rn_data, in_rm_data, in_imm;
    logic [4:0]  in_rn, in_rm, in_rd;
    logic [10:0] in_opcode;
    logic [1:0]  in_aluop;
    logic        in_alusrc, in_regwrite, in_memread, in_memwrite, in_memtoreg;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_result;
    logic        out_valid, out_ready;
    logic [63:0] BusA, BusB, out_store_data;
    logic [3:0]  ALUCtrl;
    logic [4:0]  out_rd;
    logic        out_regwrite, out_memread, out_memwrite, out_memtoreg;
    logic        hazard;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    idex_operand_stage dut (
        .CLK(CLK), .resetl(resetl),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rn_data(in_rn_data), .in_rm_data(in_rm_data), .in_imm(in_imm),
        .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
        .in_opcode(in_opcode), .in_aluop(in_aluop),
        .in_alusrc(in_alusrc), .in_regwrite(in_regwrite), .in_memread(in_memread),
        .in_memwrite(in_memwrite), .in_memtoreg(in_memtoreg),
        .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .out_memread(out_memread),
        .out_memwrite(out_memwrite), .out_memtoreg(out_memtoreg),
        .hazard(hazard)
    );

    // Reference model: the instruction currently held, as plain fields.
    typedef struct {
        bit          valid;
        bit [4:0]    rn, rm, rd;
        bit [63:0]   rn_data, rm_data, imm;
        bit          alusrc, regwrite, memread, memwrite, memtoreg;
        bit [3:0]    aluctrl;
    } instr_t;

    instr_t held;
    instr_t held_next;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit [3:0] ref_aluctrl(input bit [1:0] op, input bit [10:0] opc);
        if (op == 2'b01) return 4'b0111;
        if (op == 2'b10) begin
            if (opc == 11'b10001011000) return 4'b0010;
            if (opc == 11'b11001011000) return 4'b0110;
            if (opc == 11'b10001010000) return 4'b0000;
            if (opc == 11'b10101010000) return 4'b0001;
        end
        return 4'b0010;
    endfunction

    function automatic bit [63:0] ref_operand(input bit [4:0] idx, input bit [63:0] raw);
`ifdef FORWARDING_EN
        if (idx == 5'd31) return raw;
        if (exmem_regwrite && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd == idx) return memwb_result;
`endif
        return raw;
    endfunction

    function automatic bit ref_hazard();
        bit dep;
        if (!held.valid || !held.memread || held.rd == 5'd31) return 1'b0;
        dep = (in_rn == held.rd);
        if ((!in_alusrc || in_memwrite) && in_rm == held.rd) dep = 1'b1;
        return dep;
    endfunction

    function automatic bit ref_in_ready();
        return (!held.valid || out_ready) && !ref_hazard() && !flush;
    endfunction

    task automatic check_all();
        bit [63:0] a, m;
        a = ref_operand(held.rn, held.rn_data);
        m = ref_operand(held.rm, held.rm_data);
        check("hazard",     hazard,         ref_hazard());
        check("in_ready",   in_ready,       ref_in_ready());
        check("out_valid",  out_valid,      held.valid);
        check("BusA",       BusA,           a);
        check("BusB",       BusB,           held.alusrc ? held.imm : m);
        check("store_data", out_store_data, m);
        check("ALUCtrl",    ALUCtrl,        held.aluctrl);
        check("out_rd",     out_rd,         held.rd);
        check("regwrite",   out_regwrite,   held.valid & held.regwrite);
        check("memread",    out_memread,    held.valid & held.memread);
        check("memwrite",   out_memwrite,   held.valid & held.memwrite);
        check("memtoreg",   out_memtoreg,   held.valid & held.memtoreg);
    endtask

    task automatic model_next();
        held_next = held;
        if (flush) begin
            held_next.valid = 1'b0;
        end else if (in_valid && ref_in_ready()) begin
            held_next.valid    = 1'b1;
            held_next.rn       = in_rn;
            held_next.rm       = in_rm;
            held_next.rd       = in_rd;
            held_next.rn_data  = in_rn_data;
            held_next.rm_data  = in_rm_data;
            held_next.imm      = in_imm;
            held_next.alusrc   = in_alusrc;
            held_next.regwrite = in_regwrite;
            held_next.memread  = in_memread;
            held_next.memwrite = in_memwrite;
            held_next.memtoreg = in_memtoreg;
            held_next.aluctrl  = ref_aluctrl(in_aluop, in_opcode);
        end else if (out_ready) begin
            held_next.valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        held = '{default: 0};
    endtask

    // Inputs are set by the caller just after an edge; settle, check, clock.
    task automatic step();
        #1;
        check_all();
        model_next();
        @(posedge CLK);
        held = held_next;
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rn_data = 0; in_rm_data = 0; in_imm = 0;
        in_rn = 0; in_rm = 0; in_rd = 0; in_opcode = 0; in_aluop = 0;
        in_alusrc = 0; in_regwrite = 0; in_memread = 0; in_memwrite = 0; in_memtoreg = 0;
        flush = 0; out_ready = 1;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic rtype(input bit [4:0] rd, input bit [4:0] rn, input bit [4:0] rm,
                         input bit [10:0] opc);
        in_valid = 1; in_rd = rd; in_rn = rn; in_rm = rm; in_opcode = opc;
        in_aluop = 2'b10; in_alusrc = 0; in_regwrite = 1; in_memread = 0;
        in_memwrite = 0; in_memtoreg = 0;
        in_rn_data = 64'h1000 + rn; in_rm_data = 64'h2000 + rm; in_imm = 64'h77;
    endtask

    function automatic bit [4:0] rand_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
    endfunction

    initial begin
        bit [10:0] opcs [4];
        opcs[0] = 11'b10001011000; opcs[1] = 11'b11001011000;
        opcs[2] = 11'b10001010000; opcs[3] = 11'b10101010000;

        idle_inputs();
        resetl = 0;
        model_reset();
        #2;
        check_all();
        @(negedge CLK);
        resetl = 1;
        @(posedge CLK);
        #1;

        // ADD X3,X1,X2 with X1 in flight in EX/MEM.
        rtype(5'd3, 5'd1, 5'd2, 11'b10001011000);
        exmem_regwrite = 1; exmem_rd = 5'd1; exmem_result = 64'h10;
        step();
        in_valid = 0; out_ready = 0;
        step();
`ifdef FORWARDING_EN
        check("add_busa", BusA, 64'h10);
`else
        check("add_busa", BusA, 64'h1001);
`endif
        check("add_busb", BusB, 64'h2002);
        check("add_aluctrl", ALUCtrl, 4'b0010);
        out_ready = 1;
        step();

        // Same index in both forwarding stages, then XZR.
        rtype(5'd9, 5'd4, 5'd5, 11'b10101010000);
        exmem_regwrite = 1; exmem_rd = 5'd4; exmem_result = 64'hAA;
        memwb_regwrite = 1; memwb_rd = 5'd4; memwb_result = 64'hBB;
        step();
        in_valid = 0; out_ready = 0;
        step();
`ifdef FORWARDING_EN
        check("fwd_priority", BusA, 64'hAA);
`else
        check("fwd_priority", BusA, 64'h1004);
`endif
        out_ready = 1;
        rtype(5'd9, 5'd31, 5'd5, 11'b10101010000);
        exmem_rd = 5'd31; memwb_rd = 5'd31;
        step();
        in_valid = 0; out_ready = 0;
        step();
        check("xzr_raw", BusA, 64'h101F);
        out_ready = 1;
        idle_inputs();
        step();

        // LDUR X5 then SUB X6,X5,X7: one bubble.
        in_valid = 1; in_rd = 5'd5; in_rn = 5'd1; in_rm = 5'd0; in_imm = 64'h8;
        in_aluop = 2'b00; in_alusrc = 1; in_regwrite = 1; in_memread = 1; in_memtoreg = 1;
        step();
        rtype(5'd6, 5'd5, 5'd7, 11'b11001011000);
        #1;
        check("lu_hazard", hazard, 1'b1);
        check("lu_in_ready", in_ready, 1'b0);
        step();
        check("lu_bubble", out_valid, 1'b0);
        check("lu_clear", hazard, 1'b0);
        step();
        check("lu_sub_valid", out_valid, 1'b1);
        check("lu_sub_aluctrl", ALUCtrl, 4'b0110);
        check("lu_sub_rd", out_rd, 5'd6);
        in_valid = 0;
        step();

        // Back-pressure for three cycles.
        rtype(5'd10, 5'd1, 5'd2, 11'b10001010000);
        step();
        rtype(5'd11, 5'd2, 5'd3, 11'b10001011000);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_rd_hold", out_rd, 5'd10);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1;
        step();
        check("bp_next_rd", out_rd, 5'd11);
        check("bp_next_valid", out_valid, 1'b1);
        in_valid = 0;
        step();
        check("bp_drained", out_valid, 1'b0);

        // Flush with a valid input present.
        rtype(5'd12, 5'd1, 5'd2, 11'b10001011000);
        step();
        rtype(5'd13, 5'd3, 5'd4, 11'b11001011000);
        flush = 1;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        step();
        check("flush_valid", out_valid, 1'b0);
        check("flush_regwrite", out_regwrite, 1'b0);
        flush = 0;
        step();
        check("flush_accept_valid", out_valid, 1'b1);
        check("flush_accept_rd", out_rd, 5'd13);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 9) < 8);
            in_rn       = rand_reg();
            in_rm       = rand_reg();
            in_rd       = rand_reg();
            in_rn_data  = {$urandom, $urandom};
            in_rm_data  = {$urandom, $urandom};
            in_imm      = {$urandom, $urandom};
            in_opcode   = ($urandom_range(0, 4) == 0) ? 11'($urandom) : opcs[$urandom_range(0, 3)];
            in_aluop    = 2'($urandom_range(0, 3));
            in_alusrc   = 1'($urandom);
            in_regwrite = 1'($urandom);
            in_memread  = ($urandom_range(0, 2) == 0);
            in_memwrite = ($urandom_range(0, 3) == 0);
            in_memtoreg = 1'($urandom);
            flush       = ($urandom_range(0, 9) == 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            exmem_regwrite = 1'($urandom);
            exmem_rd       = rand_reg();
            exmem_result   = {$urandom, $urandom};
            memwb_regwrite = 1'($urandom);
            memwb_rd       = rand_reg();
            memwb_result   = {$urandom, $urandom};
            step();
        end

        // Async reset while stalled with a valid instruction held.
        flush = 0; out_ready = 0;
        rtype(5'd14, 5'd1, 5'd2, 11'b10001011000);
        step();
        step();
        exmem_regwrite = 0; memwb_regwrite = 0;
        resetl = 0;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_aluctrl", ALUCtrl, 4'b0000);
        check("rst_regwrite", out_regwrite, 1'b0);
        check("rst_busa", BusA, 64'h0);
        model_reset();
        check_all();
        @(negedge CLK);
        resetl = 1;
        in_valid = 0; out_ready = 1;
        @(posedge CLK);
        #1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_operand_stage.md
# idex_operand_stage

ID/EX pipeline register and operand-select stage that feeds the 64-bit ALU. Captures decoded register operands, the immediate and control bits from decode, and presents `BusA`, `BusB` and `ALUCtrl` one cycle later. Resolves EX/MEM and MEM/WB data forwarding, detects load-use hazards, and supports downstream back-pressure and flush through a valid/ready handshake.

## Interface
Parameters:
- none; widths fixed at 64-bit data, 5-bit register index, 11-bit opcode.

Ports:
- `CLK`  in  1  rising-edge clock; the block's only clock.
- `resetl`  in  1  asynchronous, active-low reset.
- `in_valid` / `in_ready`  in / out  1 / 1  decode-side handshake.
- `in_rn_data`, `in_rm_data`, `in_imm`  in  64 each  register-file reads and sign-extended immediate.
- `in_rn`, `in_rm`, `in_rd`  in  5 each  source and destination indices; store Rt arrives on `in_rm`.
- `in_opcode`  in  11  instruction bits [31:21].
- `in_aluop`  in  2  coarse ALU operation.
- `in_alusrc`, `in_regwrite`, `in_memread`, `in_memwrite`, `in_memtoreg`  in  1 each  decoded control bits.
- `flush`  in  1  synchronous kill of the held instruction.
- `exmem_regwrite`, `exmem_rd`, `exmem_result`  in  1/5/64  EX/MEM forwarding source.
- `memwb_regwrite`, `memwb_rd`, `memwb_result`  in  1/5/64  MEM/WB forwarding source.
- `out_valid` / `out_ready`  out / in  1 / 1  EX-side handshake.
- `BusA`, `BusB`  out  64 each  ALU operands.
- `ALUCtrl`  out  4  ALU function code.
- `out_store_data`  out  64  forwarded Rm value, used as store data.
- `out_rd`  out  5  destination index.
- `out_regwrite`, `out_memread`, `out_memwrite`, `out_memtoreg`  out  1 each  control bits; 0 whenever `out_valid`=0.
- `hazard`  out  1  load-use stall indicator.

## Operation
- Held state: one instruction slot of registered fields plus `out_valid`.
- `hazard` = `out_valid` & held memread & held rd≠31 & (`in_rn`==held rd | (uses_rm & `in_rm`==held rd)).
  - uses_rm = !`in_alusrc` | `in_memwrite`.
- `in_ready` = (!`out_valid` | `out_ready`) & !`hazard` & !`flush`.
- Capture occurs when `in_valid` & `in_ready`.
- Next-state priority: `flush` → `out_valid`<=0; else capture → load all fields, `out_valid`<=1; else if `out_ready` → `out_valid`<=0; else hold.
- ALUCtrl decode happens at capture and is registered:
  - aluop 00 → 0010 (ADD).
  - aluop 01 → 0111 (PassB).
  - aluop 10 → by opcode: 10001011000 ADD 0010, 11001011000 SUB 0110, 10001010000 AND 0000, 10101010000 ORR 0001; any other opcode → 0010.
  - aluop 11 → 0010.
- Forwarding is combinational on held operands, evaluated per source index s (Rn, Rm):
  - EX/MEM wins if `exmem_regwrite` & `exmem_rd`==s & s≠31.
  - Otherwise MEM/WB if `memwb_regwrite` & `memwb_rd`==s & s≠31.
  - Otherwise the held register value.
- `BusA` = fwd(Rn).
- `BusB` = held alusrc ? held imm : fwd(Rm).
- `out_store_data` = fwd(Rm).

## Timing
- Latency: 1 cycle from capture edge to valid outputs.
- Throughput: 1 instruction per cycle while `out_ready`=1 and no hazard.
- Reset (async, `resetl`=0): `out_valid`=0, all held fields 0, `ALUCtrl`=0000, `BusA`/`BusB`/`out_store_data`=0 (absent forwarding match), all control outputs 0. Reset mid-stall discards the held instruction.
- Load-use: exactly one bubble is inserted. The hazard clears once the load leaves (`out_ready`=1), and the dependent instruction is captured on the following edge.
- Simultaneous `flush` and `in_valid`: the input is not accepted (`in_ready`=0).
- Stall with `out_ready`=0: fields hold; forwarded outputs may change as upstream EX/MEM and MEM/WB contents change.
- Register 31 (XZR) is never a forwarding or hazard match.

## Configuration
- `FORWARDING_EN` defined: forwarding muxes are active as described.
- `FORWARDING_EN` not defined: forwarding inputs are ignored; `BusA`, `BusB` and `out_store_data` use the held register values directly. Load-use hazard detection remains.

## Structure
- Shared package `cpu_pkg`:
  - ALU control codes (AND, OR, ADD, SUB, PassB).
  - R-type opcode constants.
  - `XZR`=31.
  - aluop encodings.
- Sub-module `alu_ctrl_decode`: combinational aluop+opcode → ALUCtrl, instantiated on the capture path.

## Test plan
- Reset asserted mid-stream → `out_valid`=0, `ALUCtrl`=0000, all control outputs 0 immediately, without waiting for a clock edge.
- ADD X3,X1,X2 captured, with `exmem_rd`=1 and `exmem_result`=0x10 → next cycle `BusA`=0x10, `BusB`=`in_rm_data`, `ALUCtrl`=0010.
- Same index on both sources: EX/MEM=0xAA and MEM/WB=0xBB on Rn → `BusA`=0xAA; with rd=31 on both → raw value.
- LDUR X5 held, next instruction SUB X6,X5,X7 → `hazard`=1 and `in_ready`=0 for 1 cycle; SUB is captured the cycle after, with `ALUCtrl`=0110.
- `out_ready`=0 for 3 cycles → fields stable, `in_ready`=0, no instruction lost or duplicated.
- `flush` with `in_valid`=1 → next cycle `out_valid`=0 and `out_regwrite`=0; the input is accepted only after `flush` deasserts.
